// File: rtl/trng_vn_extractor.sv
// Von Neumann debiasing extractor for a biased ring-oscillator TRNG: pairs raw bits,
// packs extracted bits into words, buffers them in a FWFT FIFO and monitors bias.
// Optional repetition-count health test enabled by defining TRNG_HEALTH_EN.
module trng_vn_extractor #(
  parameter int unsigned BITWIDTH    = 8,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned WINDOW_LOG2 = 8,
  parameter int unsigned REP_LIMIT   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   raw_bit,
  input  logic                   enable,
  output logic [BITWIDTH-1:0]    out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   overflow,
  output logic [WINDOW_LOG2:0]   ones_count,
  output logic                   bias_valid,
  output logic                   health_fail
);

  localparam int unsigned PW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned BCW = $clog2(BITWIDTH);
  localparam int unsigned OW  = WINDOW_LOG2 + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (BITWIDTH < 2 || REP_LIMIT < 2) begin : g_bad_width
    $error("BITWIDTH and REP_LIMIT must be >= 2");
  end

  // ---------------- pair phase FSM ----------------
  typedef enum logic {PH_FIRST, PH_SECOND} phase_t;
  phase_t phase, phase_next;
  logic   held_bit;
  logic   extract;
  logic   ext_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase    <= PH_FIRST;
      held_bit <= 1'b0;
    end else begin
      phase <= phase_next;
      if (enable && phase == PH_FIRST) held_bit <= raw_bit;
    end
  end

  // A differing pair yields its first bit: 01 -> 0, 10 -> 1.
  always_comb begin
    phase_next = phase;
    extract    = 1'b0;
    ext_bit    = held_bit;
    if (!enable) begin
      phase_next = PH_FIRST;
    end else begin
      case (phase)
        PH_FIRST:  phase_next = PH_SECOND;
        PH_SECOND: begin
          phase_next = PH_FIRST;
          extract    = (held_bit != raw_bit);
        end
        default:   phase_next = PH_FIRST;
      endcase
    end
  end

  // ---------------- word assembly ----------------
  logic [BITWIDTH-2:0] shreg;
  logic [BCW-1:0]      bit_cnt;
  logic [BITWIDTH-1:0] word;
  logic                word_last;
  logic                word_done;

  assign word      = {shreg, ext_bit};
  assign word_last = (bit_cnt == BCW'(BITWIDTH - 1));
  assign word_done = extract && word_last && !health_fail;

  always_ff @(posedge clk) begin
    if (rst || health_fail) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (extract) begin
      shreg   <= word[BITWIDTH-2:0];
      bit_cnt <= word_last ? '0 : bit_cnt + 1'b1;
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [BITWIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]       rd_ptr, wr_ptr;
  logic [CW-1:0]       count;
  logic [BITWIDTH-1:0] last_data;
  logic                full, pop, push;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  assign push      = word_done && (!full || pop);
  // When empty the last popped word is presented so out_data stays stable.
  assign out_data  = out_valid ? mem[rd_ptr] : last_data;

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_data <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
      if (word_done && full && !pop) overflow <= 1'b1;
    end
  end

  // ---------------- bias monitor ----------------
  logic [WINDOW_LOG2-1:0] samp_cnt;
  logic [WINDOW_LOG2:0]   acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt   <= '0;
      acc        <= '0;
      ones_count <= '0;
      bias_valid <= 1'b0;
    end else begin
      bias_valid <= 1'b0;
      if (enable) begin
        samp_cnt <= samp_cnt + 1'b1;
        if (samp_cnt == '1) begin
          ones_count <= acc + OW'(raw_bit);
          acc        <= '0;
          bias_valid <= 1'b1;
        end else begin
          acc <= acc + OW'(raw_bit);
        end
      end
    end
  end

  // ---------------- repetition-count health test ----------------
`ifdef TRNG_HEALTH_EN
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);
  logic [RW-1:0] run, run_next;
  logic          prev_bit, have_prev;

  always_comb begin
    run_next = RW'(1);
    if (have_prev && raw_bit == prev_bit)
      run_next = (run == RW'(REP_LIMIT)) ? run : run + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run         <= '0;
      prev_bit    <= 1'b0;
      have_prev   <= 1'b0;
      health_fail <= 1'b0;
    end else if (enable) begin
      run       <= run_next;
      prev_bit  <= raw_bit;
      have_prev <= 1'b1;
      if (run_next == RW'(REP_LIMIT)) health_fail <= 1'b1;
    end
  end
`else
  assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_trng_vn_extractor.sv
// Self-checking bench for trng_vn_extractor: directed scenarios plus random stimulus
// compared every cycle against a behavioural model built from queues and counters.
module tb_trng_vn_extractor;
  localparam int unsigned BW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WL    = 8;
  localparam int unsigned REP   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          raw_bit = 1'b0;
  logic          enable = 1'b0;
  logic [BW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          overflow;
  logic [WL:0]   ones_count;
  logic          bias_valid;
  logic          health_fail;

  trng_vn_extractor #(.BITWIDTH(BW), .FIFO_DEPTH(DEPTH), .WINDOW_LOG2(WL), .REP_LIMIT(REP)) dut (
    .clk(clk), .rst(rst), .raw_bit(raw_bit), .enable(enable),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .ones_count(ones_count), .bias_valid(bias_valid),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // behavioural model state
  bit          m_half_v, m_half;
  int unsigned m_word, m_nbits;
  int unsigned q[$];
  int unsigned m_last;
  bit          m_ovf;
  int unsigned m_win_n, m_win_ones, m_ones;
  bit          m_bias;
  bit          m_hf;
  int unsigned m_run;
  bit          m_prev, m_prev_v;

  int unsigned got[$];
  int unsigned n_bias;
  int unsigned w[5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_half_v = 0; m_half = 0; m_word = 0; m_nbits = 0; q.delete(); m_last = 0;
    m_ovf = 0; m_win_n = 0; m_win_ones = 0; m_ones = 0; m_bias = 0;
    m_hf = 0; m_run = 0; m_prev = 0; m_prev_v = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    got.delete();
    n_bias = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_ones", ones_count, 0);
    chk("rst_bias", bias_valid, 0);
    chk("rst_hf", health_fail, 0);
  endtask

  task automatic step(input bit r, input bit e, input bit rd);
    bit pop, done;
    raw_bit = r; enable = e; out_ready = rd;
    if (out_valid && rd) got.push_back(out_data);
    pop  = (q.size() != 0) && rd;
    done = 0;
    if (e) begin
      if (!m_half_v) begin
        m_half = r; m_half_v = 1;
      end else begin
        m_half_v = 0;
        if (m_half != r) begin
          m_word = ((m_word << 1) | m_half) & ((1 << BW) - 1);
          m_nbits++;
          if (m_nbits == BW) begin done = 1; m_nbits = 0; end
        end
      end
    end else begin
      m_half_v = 0;
    end
    if (m_hf) begin m_word = 0; m_nbits = 0; done = 0; end
    if (pop) m_last = q.pop_front();
    if (done) begin
      if (q.size() == DEPTH) m_ovf = 1;
      else q.push_back(m_word);
    end
    m_bias = 0;
    if (e) begin
      m_win_ones += r; m_win_n++;
      if (m_win_n == (1 << WL)) begin
        m_ones = m_win_ones; m_bias = 1; m_win_n = 0; m_win_ones = 0;
      end
    end
`ifdef TRNG_HEALTH_EN
    if (e) begin
      if (m_prev_v && r == m_prev) m_run++; else m_run = 1;
      m_prev = r; m_prev_v = 1;
      if (m_run >= REP) m_hf = 1;
    end
`endif
    @(posedge clk); #1;
    if (bias_valid) n_bias++;
    chk("valid", out_valid, q.size() != 0);
    chk("data", out_data, (q.size() != 0) ? q[0] : m_last);
    chk("overflow", overflow, m_ovf);
    chk("ones_count", ones_count, m_ones);
    chk("bias_valid", bias_valid, m_bias);
    chk("health_fail", health_fail, m_hf);
  endtask

  task automatic pair(input bit a, input bit b, input bit rd);
    step(a, 1, rd);
    step(b, 1, rd);
  endtask

  // emits one extracted bit per pair: 1 -> (1,0), 0 -> (0,1)
  task automatic emit_word(input int unsigned val, input int unsigned nbits, input bit rd);
    for (int i = BW - 1; i >= int'(BW - nbits); i--) begin
      if (val[i]) pair(1, 0, rd); else pair(0, 1, rd);
    end
  endtask

  initial begin
    // 1: reset, then 16 pairs of 0,1 -> two 0x00 words
    do_reset();
    for (int i = 0; i < 16; i++) pair(0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("zeros_count", got.size(), 2);
    chk("zeros_w0", got.size() > 0 ? got[0] : 32'hdead, 0);
    chk("zeros_w1", got.size() > 1 ? got[1] : 32'hdead, 0);

    // 2: alternating 10/01 with 00 and 11 pairs inserted -> 0xAA
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) pair(1, 0, 1); else pair(0, 1, 1);
      if (i == 3) begin pair(0, 0, 1); pair(1, 1, 1); end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("aa_count", got.size(), 1);
    chk("aa_word", got.size() > 0 ? got[0] : 32'hdead, 32'hAA);

    // 3: five words with consumer stalled -> four held, fifth dropped
    do_reset();
    for (int k = 0; k < 5; k++) begin
      w[k] = $urandom_range(255);
      emit_word(w[k], BW, 0);
    end
    chk("full_valid", out_valid, 1);
    chk("full_ovf", overflow, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    chk("drain_count", got.size(), 4);
    for (int k = 0; k < 4; k++) chk("drain_word", got.size() > k ? got[k] : 32'hdead, w[k]);
    chk("drain_empty", out_valid, 0);

    // 4: word completes in the same cycle as a pop from a full FIFO
    do_reset();
    for (int k = 0; k < 5; k++) w[k] = $urandom_range(255);
    for (int k = 0; k < 4; k++) emit_word(w[k], BW, 0);
    emit_word(w[4], BW - 1, 0);
    step(w[4][0] ? 1'b1 : 1'b0, 1, 0);
    step(w[4][0] ? 1'b0 : 1'b1, 1, 1);
    step(0, 0, 0);
    chk("coinc_ovf", overflow, 0);
    chk("coinc_valid", out_valid, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 1);
    chk("coinc_count", got.size(), 5);
    for (int k = 0; k < 5; k++) chk("coinc_word", got.size() > k ? got[k] : 32'hdead, w[k]);

    // 5: bias window of all ones, then alternating
    do_reset();
    for (int i = 0; i < 256; i++) step(1, 1, 1);
    chk("bias_ones", ones_count, 256);
    chk("bias_pulses1", n_bias, 1);
    for (int i = 0; i < 256; i++) step((i % 2 == 0) ? 1'b1 : 1'b0, 1, 1);
    chk("bias_half", ones_count, 128);
    chk("bias_pulses2", n_bias, 2);

    // 6: repetition health test
    do_reset();
    for (int i = 0; i < 32; i++) step(0, 1, 1);
`ifdef TRNG_HEALTH_EN
    chk("hf_set", health_fail, 1);
`else
    chk("hf_set", health_fail, 0);
`endif
    for (int i = 0; i < 8; i++) pair(1, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
`ifdef TRNG_HEALTH_EN
    chk("hf_nopush", got.size(), 0);
`else
    chk("hf_nopush", got.size(), 1);
`endif
    do_reset();
    chk("hf_cleared", health_fail, 0);

    // 7: random traffic with a mid-run reset
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(1'($urandom_range(1)), $urandom_range(9) != 0, 1'($urandom_range(1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
